event_ingress: RTL
==================

EVENT_INGRESS -- requirements
Module: event_ingress

Interface
REQ-001 Parameters, one per line (name, default, meaning); these SHALL be provided:
 WIDTH_P  8  map width in pixels
 HEIGHT_P  8  map height in pixels
 TIMESTAMP_WIDTH_P  16  timestamp counter width
 FIFO_DEPTH_P  4  event buffer depth; power of 2, at least 2
 TICK_DIV_P  1  clock cycles per timestamp tick; at least 1
REQ-002 Ports, one per line (name, direction, width, meaning); these SHALL be provided:
 clk_i  in  1  single clock, rising edge
 reset_n_i  in  1  reset; asynchronous, active-low
 in_valid_i  in  1  raw sensor event strobe; no backpressure to sensor
 in_x_i  in  $clog2(WIDTH_P)  event column
 in_y_i  in  $clog2(HEIGHT_P)  event row
 in_polarity_i  in  1  1=ON, 0=OFF
 event_valid_o  out  1  buffered event available
 event_x_o  out  $clog2(WIDTH_P)  head event column
 event_y_o  out  $clog2(HEIGHT_P)  head event row
 event_polarity_o  out  1  head event polarity
 event_timestamp_o  out  TIMESTAMP_WIDTH_P  head event timestamp
 event_ready_i  in  1  downstream activity map accepts head
 fifo_level_o  out  $clog2(FIFO_DEPTH_P)+1  current buffer occupancy
 drop_count_o  out  16  events lost to a full buffer, saturating
 oob_count_o  out  16  events rejected for out-of-range coordinates, saturating

Function
REQ-003 Prescaler SHALL count 0..TICK_DIV_P-1 every cycle; the timestamp SHALL increment by 1 on the cycle the prescaler wraps to 0.
REQ-004 Timestamp SHALL wrap modulo 2^TIMESTAMP_WIDTH_P with no stall and no flag.
REQ-005 An event SHALL be in range iff in_x_i < WIDTH_P and in_y_i < HEIGHT_P.
REQ-006 An out-of-range event SHALL NOT be pushed; oob_count_o SHALL increment, saturating at 0xFFFF.
REQ-007 An in-range event SHALL be pushed with the timestamp value held in that cycle (pre-increment value).
REQ-008 Push condition: in range, and (fifo_level_o < FIFO_DEPTH_P or a pop occurs in the same cycle).
REQ-009 An in-range event failing REQ-008 SHALL be discarded; drop_count_o SHALL increment, saturating at 0xFFFF.
REQ-010 Pop SHALL occur iff event_valid_o and event_ready_i are both 1 in the same cycle.
REQ-011 event_valid_o SHALL equal (fifo_level_o != 0), driven from registered state only; it SHALL NOT depend combinationally on any input.
REQ-012 Event output fields SHALL present the oldest stored entry (show-ahead) and SHALL hold stable while event_valid_o=1 and event_ready_i=0.
REQ-013 Latency: an event pushed in cycle N SHALL appear on the outputs in cycle N+1 when the buffer was empty; FIFO order SHALL be strict.
REQ-014 Simultaneous push and pop SHALL leave fifo_level_o unchanged; write and read pointers SHALL wrap modulo FIFO_DEPTH_P.
REQ-015 event_ready_i asserted while event_valid_o=0 SHALL have no effect.
REQ-016 When event_valid_o=0, event output fields SHALL be don't-care; the bench SHALL NOT check them.

Reset
REQ-017 reset_n_i low SHALL immediately clear, without waiting for a clock edge: prescaler, timestamp, pointers, level, both counters.
REQ-018 Output reset values: event_valid_o=0, fifo_level_o=0, drop_count_o=0, oob_count_o=0, event fields=0.
REQ-019 Reset asserted mid-operation SHALL discard all buffered events; no push or pop SHALL occur while reset_n_i=0.
REQ-020 Deassertion is synchronised externally; the first active edge after release SHALL begin counting from timestamp 0.

Verification
REQ-021 Scenario: TICK_DIV_P=4, single event (3,5,ON) at cycle 10 after reset -> next cycle event_valid_o=1, x=3, y=5, pol=1, timestamp=2.
REQ-022 Scenario: event_ready_i=0, 6 in-range events, depth 4 -> fifo_level_o=4, drop_count_o=2; drain returns the first 4 events in order.
REQ-023 Scenario: full buffer, push and pop in the same cycle -> level stays 4, drop_count_o unchanged, new event appears last.
REQ-024 Scenario: WIDTH_P=6, event x=7 -> not pushed, oob_count_o=1, level 0.
REQ-025 Scenario: TIMESTAMP_WIDTH_P=4, TICK_DIV_P=1 -> event at tick 15 tagged 15, event one cycle later tagged 0.
REQ-026 Scenario: reset_n_i pulsed low mid-cycle with 3 buffered events -> outputs reach reset values before the next clock edge; the buffer is empty afterwards.

Source files
------------

// File: rtl/event_ingress_if.sv
// Sensor-to-activity-map event bus: raw sensor strobe in, show-ahead buffered event out.
// Handshake: a buffered event transfers when event_valid_o and event_ready_i are both high on a rising edge; the sensor side has no backpressure.
interface event_ingress_if #(
    parameter int WIDTH_P           = 8,
    parameter int HEIGHT_P          = 8,
    parameter int TIMESTAMP_WIDTH_P = 16,
    parameter int FIFO_DEPTH_P      = 4
);
    localparam int XW = (WIDTH_P > 1) ? $clog2(WIDTH_P) : 1;
    localparam int YW = (HEIGHT_P > 1) ? $clog2(HEIGHT_P) : 1;
    localparam int LW = $clog2(FIFO_DEPTH_P) + 1;

    logic                         in_valid_i;
    logic [XW-1:0]                in_x_i;
    logic [YW-1:0]                in_y_i;
    logic                         in_polarity_i;
    logic                         event_valid_o;
    logic [XW-1:0]                event_x_o;
    logic [YW-1:0]                event_y_o;
    logic                         event_polarity_o;
    logic [TIMESTAMP_WIDTH_P-1:0] event_timestamp_o;
    logic                         event_ready_i;
    logic [LW-1:0]                fifo_level_o;
    logic [15:0]                  drop_count_o;
    logic [15:0]                  oob_count_o;

    modport slave (
        input  in_valid_i, in_x_i, in_y_i, in_polarity_i, event_ready_i,
        output event_valid_o, event_x_o, event_y_o, event_polarity_o,
               event_timestamp_o, fifo_level_o, drop_count_o, oob_count_o
    );

    modport master (
        output in_valid_i, in_x_i, in_y_i, in_polarity_i, event_ready_i,
        input  event_valid_o, event_x_o, event_y_o, event_polarity_o,
               event_timestamp_o, fifo_level_o, drop_count_o, oob_count_o
    );
endinterface

// File: rtl/event_ingress.sv
// Timestamps raw sensor events, rejects out-of-map coordinates and buffers the rest
// in a small show-ahead FIFO, counting events lost to range errors or a full buffer.
module event_ingress #(
    parameter int WIDTH_P           = 8,
    parameter int HEIGHT_P          = 8,
    parameter int TIMESTAMP_WIDTH_P = 16,
    parameter int FIFO_DEPTH_P      = 4,
    parameter int TICK_DIV_P        = 1
) (
    input logic           clk_i,
    input logic           reset_n_i,
    event_ingress_if.slave bus
);
    localparam int XW = (WIDTH_P > 1) ? $clog2(WIDTH_P) : 1;
    localparam int YW = (HEIGHT_P > 1) ? $clog2(HEIGHT_P) : 1;
    localparam int PW = $clog2(FIFO_DEPTH_P);
    localparam int LW = PW + 1;
    localparam int SW = (TICK_DIV_P > 1) ? $clog2(TICK_DIV_P) : 1;
    localparam int TW = TIMESTAMP_WIDTH_P;

    localparam logic [XW:0]   X_LIM     = (XW + 1)'(WIDTH_P);
    localparam logic [YW:0]   Y_LIM     = (YW + 1)'(HEIGHT_P);
    localparam logic [SW-1:0] PRESC_MAX = SW'(TICK_DIV_P - 1);
    localparam logic [LW-1:0] DEPTH     = LW'(FIFO_DEPTH_P);

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic          pol;
        logic [TW-1:0] ts;
    } entry_t;

    logic [SW-1:0] presc_q, presc_d;
    logic [TW-1:0] ts_q, ts_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [15:0]   drop_q, drop_d;
    logic [15:0]   oob_q, oob_d;
    entry_t        mem_q [FIFO_DEPTH_P];

    logic   in_range, full, pop, push, drop, oob, tick;
    entry_t head;

    assign in_range = ({1'b0, bus.in_x_i} < X_LIM) && ({1'b0, bus.in_y_i} < Y_LIM);
    assign full     = (level_q == DEPTH);
    assign pop      = (level_q != '0) && bus.event_ready_i;
    // A full buffer still accepts an event when the head leaves in the same cycle.
    assign push     = bus.in_valid_i && in_range && (!full || pop);
    assign drop     = bus.in_valid_i && in_range && !push;
    assign oob      = bus.in_valid_i && !in_range;
    assign tick     = (presc_q == PRESC_MAX);

    always_comb begin
        presc_d  = tick ? '0 : presc_q + 1'b1;
        ts_d     = tick ? ts_q + 1'b1 : ts_q;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        drop_d = (drop && (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;
        oob_d  = (oob && (oob_q != 16'hFFFF)) ? oob_q + 16'd1 : oob_q;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            presc_q  <= '0;
            ts_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            drop_q   <= '0;
            oob_q    <= '0;
        end else begin
            presc_q  <= presc_d;
            ts_q     <= ts_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            drop_q   <= drop_d;
            oob_q    <= oob_d;
        end
    end

    // Storage is not reset; the outputs are masked by occupancy instead.
    always_ff @(posedge clk_i) begin
        if (push && reset_n_i) begin
            mem_q[wr_ptr_q] <= '{x: bus.in_x_i, y: bus.in_y_i, pol: bus.in_polarity_i, ts: ts_q};
        end
    end

    assign head                  = mem_q[rd_ptr_q];
    assign bus.event_valid_o     = (level_q != '0);
    assign bus.event_x_o         = bus.event_valid_o ? head.x : '0;
    assign bus.event_y_o         = bus.event_valid_o ? head.y : '0;
    assign bus.event_polarity_o  = bus.event_valid_o ? head.pol : 1'b0;
    assign bus.event_timestamp_o = bus.event_valid_o ? head.ts : '0;
    assign bus.fifo_level_o      = level_q;
    assign bus.drop_count_o      = drop_q;
    assign bus.oob_count_o       = oob_q;
endmodule
